// File: rtl/instruction_fetcher.sv
// Fetch stage: PC register, icache handshake, JAL/branch predecode
// and a circular instruction queue feeding dispatch.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (global enable)
//   if_to_ic_en/pc      : icache request, held until ic_to_if_ready
//   ic_to_if_ready/inst : icache response pulse and word
//   if_to_bp_pc         : predictor query PC (current pc)
//   bp_to_if_prediction : predictor taken bit, same cycle
//   if_to_dp_*          : queue head to dispatch
//   dp_to_if_ready      : dispatch pops the head
//   rob_to_if_flush/target_pc : redirect, empties the queue
module instruction_fetcher #(
  parameter int QUEUE_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        if_to_ic_en,
  output logic [31:0] if_to_ic_pc,
  input  logic        ic_to_if_ready,
  input  logic [31:0] ic_to_if_inst,
  output logic [31:0] if_to_bp_pc,
  input  logic        bp_to_if_prediction,
  output logic        if_to_dp_valid,
  output logic [31:0] if_to_dp_inst,
  output logic [31:0] if_to_dp_pc,
  output logic        if_to_dp_pred_br,
  input  logic        dp_to_if_ready,
  input  logic        rob_to_if_flush,
  input  logic [31:0] rob_to_if_target_pc
);

  localparam int DEPTH = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] FULL =
    (QUEUE_WIDTH+1)'(DEPTH);

  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic {
    IDLE,
    WAIT_IC
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]            r_pc;
  logic [QUEUE_WIDTH-1:0] r_head;
  logic [QUEUE_WIDTH-1:0] r_tail;
  logic [QUEUE_WIDTH:0]   r_count;

  logic [31:0] r_q_inst [DEPTH];
  logic [31:0] r_q_pc   [DEPTH];
  logic        r_q_pred [DEPTH];

  logic [6:0]  w_opcode;
  logic        w_is_jal;
  logic        w_is_br;
  logic [31:0] w_j_imm;
  logic [31:0] w_b_imm;
  logic [31:0] w_next_pc;
  logic        w_pred_br;
  logic        w_push;
  logic        w_pop;
  logic        w_ic_en;

  assign w_opcode = ic_to_if_inst[6:0];
  assign w_is_jal = (w_opcode == OP_JAL);
  assign w_is_br  = (w_opcode == OP_BR);

  assign w_j_imm = {{12{ic_to_if_inst[31]}},
                    ic_to_if_inst[19:12],
                    ic_to_if_inst[20],
                    ic_to_if_inst[30:21], 1'b0};

  assign w_b_imm = {{20{ic_to_if_inst[31]}},
                    ic_to_if_inst[7],
                    ic_to_if_inst[30:25],
                    ic_to_if_inst[11:8], 1'b0};

  always_comb begin
    w_next_pc = r_pc + 32'd4;
    w_pred_br = 1'b0;
    unique case (1'b1)
      w_is_jal: begin
        w_next_pc = r_pc + w_j_imm;
        w_pred_br = 1'b1;
      end
      (w_is_br && bp_to_if_prediction): begin
        w_next_pc = r_pc + w_b_imm;
        w_pred_br = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ic_en     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_count < FULL)
          w_state_nxt = WAIT_IC;
      end
      WAIT_IC: begin
        w_ic_en = 1'b1;
        if (ic_to_if_ready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Space was reserved when entering WAIT_IC, so a push cannot overflow.
  assign w_push = (r_state == WAIT_IC) && ic_to_if_ready;
  assign w_pop  = (r_count != '0) && dp_to_if_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (rob_to_if_flush) begin
        r_state <= IDLE;
        r_pc    <= rob_to_if_target_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_push) begin
          r_pc   <= w_next_pc;
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop)
          r_head <= r_head + 1'b1;
        if (w_push && !w_pop)
          r_count <= r_count + 1'b1;
        else if (!w_push && w_pop)
          r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in &&
        !rob_to_if_flush && w_push) begin
      r_q_inst[r_tail] <= ic_to_if_inst;
      r_q_pc[r_tail]   <= r_pc;
      r_q_pred[r_tail] <= w_pred_br;
    end
  end

  assign if_to_ic_en = w_ic_en;
  assign if_to_ic_pc = r_pc;
  assign if_to_bp_pc = r_pc;

  // Head fields read as zero when empty so stale slots never leak out.
  assign if_to_dp_valid   = (r_count != '0);
  assign if_to_dp_inst    = if_to_dp_valid ? r_q_inst[r_head] : '0;
  assign if_to_dp_pc      = if_to_dp_valid ? r_q_pc[r_head] : '0;
  assign if_to_dp_pred_br = if_to_dp_valid ? r_q_pred[r_head] : 1'b0;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Self-checking bench for instruction_fetcher: scoreboard of
// expected queue entries, icache/dispatch/ROB driven per scenario.
module tb_instruction_fetcher;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        if_to_ic_en;
  logic [31:0] if_to_ic_pc;
  logic        ic_to_if_ready = 1'b0;
  logic [31:0] ic_to_if_inst = '0;
  logic [31:0] if_to_bp_pc;
  logic        bp_to_if_prediction = 1'b0;
  logic        if_to_dp_valid;
  logic [31:0] if_to_dp_inst;
  logic [31:0] if_to_dp_pc;
  logic        if_to_dp_pred_br;
  logic        dp_to_if_ready = 1'b0;
  logic        rob_to_if_flush = 1'b0;
  logic [31:0] rob_to_if_target_pc = '0;

  instruction_fetcher dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .if_to_ic_en(if_to_ic_en),
    .if_to_ic_pc(if_to_ic_pc),
    .ic_to_if_ready(ic_to_if_ready),
    .ic_to_if_inst(ic_to_if_inst),
    .if_to_bp_pc(if_to_bp_pc),
    .bp_to_if_prediction(bp_to_if_prediction),
    .if_to_dp_valid(if_to_dp_valid),
    .if_to_dp_inst(if_to_dp_inst),
    .if_to_dp_pc(if_to_dp_pc),
    .if_to_dp_pred_br(if_to_dp_pred_br),
    .dp_to_if_ready(dp_to_if_ready),
    .rob_to_if_flush(rob_to_if_flush),
    .rob_to_if_target_pc(rob_to_if_target_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pb;
  } ent_t;

  ent_t sb[$];
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mpc;

  localparam logic [31:0] NOP = 32'h0000_0013;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Reference next-PC / predicted flag for one fetched word.
  function automatic void model(input logic [31:0] pc,
                                input logic [31:0] inst,
                                input logic pred,
                                output logic [31:0] npc,
                                output logic pb);
    logic [31:0] j;
    logic [31:0] b;
    j = {{12{inst[31]}}, inst[19:12], inst[20],
         inst[30:21], 1'b0};
    b = {{20{inst[31]}}, inst[7], inst[30:25],
         inst[11:8], 1'b0};
    npc = pc + 32'd4;
    pb = 1'b0;
    if (inst[6:0] == 7'b1101111) begin
      npc = pc + j;
      pb = 1'b1;
    end else if (inst[6:0] == 7'b1100011 && pred) begin
      npc = pc + b;
      pb = 1'b1;
    end
  endfunction

  // Waits (bounded) for a request, then returns one response word.
  task automatic serve(input logic [31:0] inst,
                       input logic pred,
                       output logic ok,
                       output logic [31:0] req_pc,
                       output logic [31:0] bp_pc);
    int n = 0;
    while (!if_to_ic_en && n < 20) begin
      step();
      n++;
    end
    ok = if_to_ic_en;
    req_pc = if_to_ic_pc;
    ic_to_if_inst = inst;
    bp_to_if_prediction = pred;
    ic_to_if_ready = 1'b1;
    #1;
    bp_pc = if_to_bp_pc;
    step();
    ic_to_if_ready = 1'b0;
    ic_to_if_inst = '0;
    bp_to_if_prediction = 1'b0;
  endtask

  task automatic do_flush(input logic [31:0] tgt);
    rob_to_if_flush = 1'b1;
    rob_to_if_target_pc = tgt;
    step();
    rob_to_if_flush = 1'b0;
    rob_to_if_target_pc = '0;
    mpc = tgt;
    sb.delete();
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    step();
    step();
    vectors++;
    if (if_to_ic_en !== 1'b0 || if_to_ic_pc !== 32'h0 ||
        if_to_bp_pc !== 32'h0 || if_to_dp_valid !== 1'b0 ||
        if_to_dp_inst !== 32'h0 || if_to_dp_pc !== 32'h0 ||
        if_to_dp_pred_br !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: en=%b icpc=%h bppc=%h v=%b inst=%h pc=%h pb=%b (want all 0)",
               if_to_ic_en, if_to_ic_pc, if_to_bp_pc, if_to_dp_valid,
               if_to_dp_inst, if_to_dp_pc, if_to_dp_pred_br);
    end
    rst_in = 1'b0;
    mpc = 32'h0;
    sb.delete();
    step();
    vectors++;
    if (if_to_ic_en !== 1'b1) begin
      miscompares++;
      $display("FAIL first_request: en=%b want 1", if_to_ic_en);
    end
  endtask

  task automatic test_nop_stream();
    logic ok;
    logic [31:0] rp, bp, npc;
    logic pb;
    ent_t e;
    for (int i = 0; i < 4; i++) begin
      serve(NOP, 1'b0, ok, rp, bp);
      vectors++;
      if (!ok || rp !== mpc) begin
        miscompares++;
        $display("FAIL nop_req_pc: ok=%b pc=%h want %h", ok, rp, mpc);
      end
      vectors++;
      if (if_to_ic_en !== 1'b0) begin
        miscompares++;
        $display("FAIL nop_en_gap: en=%b want 0", if_to_ic_en);
      end
      model(mpc, NOP, 1'b0, npc, pb);
      sb.push_back('{NOP, mpc, pb});
      mpc = npc;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (if_to_dp_valid !== 1'b1 || if_to_dp_inst !== e.inst ||
          if_to_dp_pc !== e.pc || if_to_dp_pred_br !== e.pb) begin
        miscompares++;
        $display("FAIL nop_head: v=%b inst=%h pc=%h pb=%b want %h %h %b",
                 if_to_dp_valid, if_to_dp_inst, if_to_dp_pc,
                 if_to_dp_pred_br, e.inst, e.pc, e.pb);
      end
      dp_to_if_ready = 1'b1;
      step();
      dp_to_if_ready = 1'b0;
    end
  endtask

  task automatic test_jal();
    logic ok;
    logic [31:0] rp, bp;
    do_flush(32'h20);
    serve(32'h0100_006F, 1'b0, ok, rp, bp);
    vectors++;
    if (!ok || rp !== 32'h20) begin
      miscompares++;
      $display("FAIL jal_req_pc: pc=%h want 00000020", rp);
    end
    vectors++;
    if (if_to_dp_pred_br !== 1'b1 || if_to_dp_pc !== 32'h20 ||
        if_to_dp_inst !== 32'h0100_006F) begin
      miscompares++;
      $display("FAIL jal_entry: pb=%b pc=%h inst=%h want 1 00000020 0100006f",
               if_to_dp_pred_br, if_to_dp_pc, if_to_dp_inst);
    end
    serve(NOP, 1'b0, ok, rp, bp);
    vectors++;
    if (!ok || rp !== 32'h30) begin
      miscompares++;
      $display("FAIL jal_target: pc=%h want 00000030", rp);
    end
  endtask

  task automatic test_branch();
    logic ok;
    logic [31:0] rp, bp;
    logic [31:0] want_pc;
    for (int p = 1; p >= 0; p--) begin
      want_pc = (p == 1) ? 32'h48 : 32'h44;
      do_flush(32'h40);
      serve(32'h0000_0463, p[0], ok, rp, bp);
      vectors++;
      if (!ok || bp !== 32'h40) begin
        miscompares++;
        $display("FAIL br_bp_pc: pc=%h want 00000040", bp);
      end
      vectors++;
      if (if_to_dp_pred_br !== p[0] || if_to_dp_pc !== 32'h40) begin
        miscompares++;
        $display("FAIL br_pred_flag: pb=%b pc=%h want %b 00000040",
                 if_to_dp_pred_br, if_to_dp_pc, p[0]);
      end
      serve(NOP, 1'b0, ok, rp, bp);
      vectors++;
      if (!ok || rp !== want_pc) begin
        miscompares++;
        $display("FAIL br_next_pc: pc=%h want %h", rp, want_pc);
      end
    end
  endtask

  task automatic test_full_wrap();
    logic ok;
    logic [31:0] rp, bp, npc, inst;
    logic pb, pred;
    ent_t e;
    do_flush(32'h100);
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        for (int k = 0; k < 5; k++) begin
          vectors++;
          if (if_to_ic_en !== 1'b0 || if_to_dp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_hold: en=%b v=%b want 0 1",
                     if_to_ic_en, if_to_dp_valid);
          end
          step();
        end
        e = sb.pop_front();
        vectors++;
        if (if_to_dp_pc !== e.pc || if_to_dp_inst !== e.inst ||
            if_to_dp_pred_br !== e.pb) begin
          miscompares++;
          $display("FAIL full_pop: pc=%h inst=%h want %h %h",
                   if_to_dp_pc, if_to_dp_inst, e.pc, e.inst);
        end
        dp_to_if_ready = 1'b1;
        step();
        dp_to_if_ready = 1'b0;
      end
      inst = $urandom();
      case ($urandom_range(0, 4))
        0: inst[6:0] = 7'h13;
        1: inst[6:0] = 7'h33;
        2: inst[6:0] = 7'h67;
        3: inst[6:0] = 7'h6F;
        default: inst[6:0] = 7'h63;
      endcase
      pred = 1'($urandom_range(0, 1));
      serve(inst, pred, ok, rp, bp);
      vectors++;
      if (!ok || rp !== mpc) begin
        miscompares++;
        $display("FAIL fill_req: i=%0d ok=%b pc=%h want %h", i, ok, rp, mpc);
      end
      model(mpc, inst, pred, npc, pb);
      sb.push_back('{inst, mpc, pb});
      mpc = npc;
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (if_to_ic_en !== 1'b0) begin
        miscompares++;
        $display("FAIL refill_once: en=%b want 0", if_to_ic_en);
      end
      step();
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (if_to_dp_valid !== 1'b1 || if_to_dp_inst !== e.inst ||
          if_to_dp_pc !== e.pc || if_to_dp_pred_br !== e.pb) begin
        miscompares++;
        $display("FAIL wrap_head: v=%b inst=%h pc=%h pb=%b want %h %h %b",
                 if_to_dp_valid, if_to_dp_inst, if_to_dp_pc,
                 if_to_dp_pred_br, e.inst, e.pc, e.pb);
      end
      dp_to_if_ready = 1'b1;
      step();
      dp_to_if_ready = 1'b0;
    end
    vectors++;
    if (if_to_dp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_empty: v=%b want 0", if_to_dp_valid);
    end
  endtask

  task automatic test_flush_collision();
    logic ok;
    logic [31:0] rp, bp;
    int n = 0;
    serve(NOP, 1'b0, ok, rp, bp);
    serve(NOP, 1'b0, ok, rp, bp);
    while (!if_to_ic_en && n < 20) begin
      step();
      n++;
    end
    ic_to_if_ready = 1'b1;
    ic_to_if_inst = 32'h0100_006F;
    dp_to_if_ready = 1'b1;
    do_flush(32'h1000);
    ic_to_if_ready = 1'b0;
    ic_to_if_inst = '0;
    dp_to_if_ready = 1'b0;
    vectors++;
    if (if_to_dp_valid !== 1'b0 || if_to_ic_en !== 1'b0 ||
        if_to_ic_pc !== 32'h1000) begin
      miscompares++;
      $display("FAIL flush_state: v=%b en=%b pc=%h want 0 0 00001000",
               if_to_dp_valid, if_to_ic_en, if_to_ic_pc);
    end
    serve(NOP, 1'b0, ok, rp, bp);
    vectors++;
    if (!ok || rp !== 32'h1000) begin
      miscompares++;
      $display("FAIL flush_target: pc=%h want 00001000", rp);
    end
    sb.push_back('{NOP, 32'h1000, 1'b0});
    mpc = 32'h1004;
  endtask

  task automatic test_stall();
    logic ok;
    logic [31:0] rp, bp;
    ent_t e;
    int n = 0;
    while (!if_to_ic_en && n < 20) begin
      step();
      n++;
    end
    rdy_in = 1'b0;
    dp_to_if_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ic_to_if_ready = ~i[0];
      ic_to_if_inst = 32'h0100_006F;
      step();
      vectors++;
      if (if_to_ic_en !== 1'b1 || if_to_ic_pc !== mpc ||
          if_to_dp_valid !== 1'b1 || if_to_dp_pc !== 32'h1000) begin
        miscompares++;
        $display("FAIL stall_hold: en=%b pc=%h v=%b hpc=%h want 1 %h 1 00001000",
                 if_to_ic_en, if_to_ic_pc, if_to_dp_valid,
                 if_to_dp_pc, mpc);
      end
    end
    ic_to_if_ready = 1'b0;
    ic_to_if_inst = '0;
    dp_to_if_ready = 1'b0;
    rdy_in = 1'b1;
    serve(NOP, 1'b0, ok, rp, bp);
    vectors++;
    if (!ok || rp !== 32'h1004) begin
      miscompares++;
      $display("FAIL stall_resume: pc=%h want 00001004", rp);
    end
    sb.push_back('{NOP, 32'h1004, 1'b0});
    while (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (if_to_dp_valid !== 1'b1 || if_to_dp_pc !== e.pc ||
          if_to_dp_inst !== e.inst) begin
        miscompares++;
        $display("FAIL stall_head: v=%b pc=%h want %h",
                 if_to_dp_valid, if_to_dp_pc, e.pc);
      end
      dp_to_if_ready = 1'b1;
      step();
      dp_to_if_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!if_to_ic_en && n < 20) begin
      step();
      n++;
    end
    rst_in = 1'b1;
    ic_to_if_ready = 1'b1;
    ic_to_if_inst = NOP;
    step();
    rst_in = 1'b0;
    ic_to_if_ready = 1'b0;
    ic_to_if_inst = '0;
    vectors++;
    if (if_to_ic_en !== 1'b0 || if_to_ic_pc !== 32'h0 ||
        if_to_dp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: en=%b pc=%h v=%b want 0 0 0",
               if_to_ic_en, if_to_ic_pc, if_to_dp_valid);
    end
    step();
    vectors++;
    if (if_to_ic_en !== 1'b1 || if_to_ic_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_req: en=%b pc=%h want 1 0",
               if_to_ic_en, if_to_ic_pc);
    end
  endtask

  initial begin
    test_reset();
    test_nop_stream();
    test_jal();
    test_branch();
    test_full_wrap();
    test_flush_collision();
    test_stall();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetcher.md
Name: instruction_fetcher

Overview:
Front-end fetch stage that directly feeds the branch predictor query port and the dispatch stage. It holds the PC and fetches one 32-bit instruction at a time from the icache. It predecodes JAL and conditional branches, using the predictor's taken bit to select the next PC. Fetched instructions are buffered in a circular queue for dispatch. A ROB flush redirects fetch and empties the queue.

Parameters:
QUEUE_WIDTH, 4, log2 of instruction-queue depth (DEPTH = 2**QUEUE_WIDTH = 16 entries)

Ports:
clk_in  input  1  clock
rst_in  input  1  reset, synchronous, active-high
rdy_in  input  1  global enable; when low all state holds
if_to_ic_en  output  1  icache request valid
if_to_ic_pc  output  32  icache request address
ic_to_if_ready  input  1  icache response valid, single-cycle pulse
ic_to_if_inst  input  32  instruction word, valid with ic_to_if_ready
if_to_bp_pc  output  32  predictor query PC; combinational, equals current pc register
bp_to_if_prediction  input  1  predictor taken bit; combinational, same cycle
if_to_dp_valid  output  1  queue head valid
if_to_dp_inst  output  32  head instruction
if_to_dp_pc  output  32  head PC
if_to_dp_pred_br  output  1  head predicted-taken flag; 1 for JAL and for predicted-taken branches
dp_to_if_ready  input  1  dispatch accepts head this cycle
rob_to_if_flush  input  1  mispredict/redirect pulse
rob_to_if_target_pc  input  32  redirect target

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset state: pc=0, state=IDLE, head=tail=count=0. All outputs are 0 except if_to_bp_pc/if_to_ic_pc, which equal pc (0).
- rdy_in=0: no register changes. Combinational outputs still reflect the held state.
- FSM, two states:
  - IDLE: if count<DEPTH, go to WAIT_IC next cycle; otherwise stay in IDLE.
  - WAIT_IC: if_to_ic_en=1 and if_to_ic_pc=pc, held stable until ic_to_if_ready.
  - On ic_to_if_ready in WAIT_IC: push the entry, update pc, return to IDLE.
  - One request is outstanding at most. Minimum two cycles per instruction.
- Predecode of ic_to_if_inst, applied on the response cycle:
  - opcode 1101111 (JAL): next pc = pc + J-imm. J-imm is sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}. pred_br=1.
  - opcode 1100011 (BRANCH): if bp_to_if_prediction=1, next pc = pc + B-imm and pred_br=1; otherwise next pc = pc+4 and pred_br=0. B-imm is sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - All other opcodes, including JALR: next pc = pc+4, pred_br=0.
  - PC arithmetic is 32-bit, wrap-around modulo 2^32.
- Queue:
  - DEPTH entries of {inst, pc, pred_br}. Head and tail are QUEUE_WIDTH-bit pointers that wrap naturally; count is QUEUE_WIDTH+1 bits.
  - if_to_dp_valid = (count!=0). Head fields come from the registered array at head.
  - Pop when if_to_dp_valid && dp_to_if_ready.
  - Push and pop may occur in the same cycle; count is unchanged in that case.
  - Space is checked on the IDLE->WAIT_IC transition. Pops only free entries, so a push never overflows.
  - A pop when empty is ignored.
- Flush (rob_to_if_flush=1 while rdy_in=1) has priority over everything else:
  - pc<=rob_to_if_target_pc; head=tail=count=0; state<=IDLE.
  - A same-cycle ic_to_if_ready is discarded. A same-cycle pop is discarded.
  - if_to_ic_en drops the next cycle. The icache aborts a request when en deasserts.
- Reset mid-request: same effect as reset, and en drops next cycle.

Test Plan:
- Reset, then icache returns NOP (0x00000013) at each request -> requests at pc 0,4,8,... Queue shows pc 0 first with pred_br=0. en is high only in WAIT_IC, at most one request per two cycles.
- JAL x0,+16 (0x0100006F) at pc=0x20 -> entry pred_br=1. Next request pc=0x30.
- BEQ with +8 (0x00000463) at pc=0x40 -> prediction=1: next pc 0x48, pred_br=1. prediction=0: next pc 0x44, pred_br=0. if_to_bp_pc=0x40 during the response cycle.
- dp_to_if_ready held 0 -> exactly 16 entries fill. FSM stays in IDLE with en=0. One pop -> exactly one further request issues. Pop order matches push order across pointer wrap.
- Flush with target 0x1000 in the same cycle as ic_to_if_ready and a pop -> queue empty next cycle, response dropped. Next request pc=0x1000.
- rdy_in=0 for 5 cycles during WAIT_IC while ic_to_if_ready pulses -> no state change. Resume after rdy_in returns high.
